// File: rtl/temporal_buffer_ctrl.sv
// Sequencer for the per-flip temporal literal store. It fills NSAT rows from
// the flip evaluator, waits for the heuristic selector's choice, issues the
// read row and presents the stored literals downstream with valid/ready.

`default_nettype none

module temporal_buffer_ctrl #(
  parameter int NSAT = 3,
  parameter int LAW  = 12,
  parameter int SIZE = 2,
  localparam int IW = (NSAT > 1) ? $clog2(NSAT) : 1,
  localparam int DW = SIZE * LAW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          cand_valid_i,
  output logic          cand_ready_o,
  input  logic [DW-1:0] cand_literals_i,
  input  logic          sel_valid_i,
  input  logic [IW-1:0] sel_index_i,
  output logic          sel_ready_o,
  output logic          buf_wr_en_o,
  output logic [IW-1:0] buf_wr_index_o,
  output logic [DW-1:0] buf_wr_literals_o,
  output logic [IW-1:0] buf_rd_index_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] out_index_o,
  output logic          busy_o,
  output logic          sel_err_o
);

  // Last valid store row; full-width so the compare never truncates.
  localparam logic [IW-1:0] LAST_ROW = IW'(NSAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_SEL,
    S_READ,
    S_PRESENT
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] count, count_next;
  logic [IW-1:0] rd_index, rd_index_next;
  logic [DW-1:0] last_literals, last_literals_next;
  logic          sel_err, sel_err_next;

  // State and datapath registers; cleared asynchronously, store contents untouched.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      count         <= '0;
      rd_index      <= '0;
      last_literals <= '0;
      sel_err       <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      rd_index      <= rd_index_next;
      last_literals <= last_literals_next;
      sel_err       <= sel_err_next;
    end
  end

  // Next-state logic; abort overrides every transition taken in the same cycle.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next         = state;
    count_next         = count;
    rd_index_next      = rd_index;
    last_literals_next = last_literals;
    sel_err_next       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = S_FILL;
          count_next = '0;
        end
      end
      S_FILL: begin
        if (cand_valid_i) begin
          // Keep the newest row so passthrough reads of the last row see it.
          last_literals_next = cand_literals_i;
          if (count == LAST_ROW) state_next = S_WAIT_SEL;
          else                   count_next = count + 1'b1;
        end
      end
      S_WAIT_SEL: begin
        if (sel_valid_i) begin
          if (sel_index_i <= LAST_ROW) begin
            rd_index_next = sel_index_i;
            state_next    = S_READ;
          end else begin
            sel_err_next = 1'b1;
          end
        end
      end
      S_READ: begin
        // One cycle for the store's registered read.
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready_i) begin
          state_next    = S_IDLE;
          rd_index_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort_i) begin
      state_next    = S_IDLE;
      count_next    = '0;
      rd_index_next = '0;
      sel_err_next  = 1'b0;
    end
  end

  // Output decode; the write port is combinational so an abort-cycle write still lands.
  always_comb begin
    cand_ready_o      = 1'b0;
    sel_ready_o       = 1'b0;
    buf_wr_en_o       = 1'b0;
    buf_wr_index_o    = '0;
    buf_wr_literals_o = '0;
    out_valid_o       = 1'b0;

    unique case (state)
      S_FILL: begin
        cand_ready_o      = 1'b1;
        buf_wr_en_o       = cand_valid_i;
        buf_wr_index_o    = count;
        buf_wr_literals_o = cand_literals_i;
      end
      S_WAIT_SEL: begin
        sel_ready_o = 1'b1;
      end
      S_READ: begin
        buf_wr_literals_o = last_literals;
      end
      S_PRESENT: begin
        buf_wr_literals_o = last_literals;
        out_valid_o       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign buf_rd_index_o = rd_index;
  assign out_index_o    = rd_index;
  assign busy_o         = (state != S_IDLE);
  assign sel_err_o      = sel_err;

endmodule

`default_nettype wire
